// File: rtl/vector_alu_pkg.sv
// Shared opcode constants, state encoding and default widths
// for the vector ALU issue stage.
package vector_alu_pkg;

  localparam int VA_DATA_W = 64;
  localparam int VA_ID_W   = 5;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_PASS = 5'b00001;
  localparam logic [4:0] OP_SUB  = 5'b00010;
  localparam logic [4:0] OP_AND  = 5'b00011;
  localparam logic [4:0] OP_OR   = 5'b00100;
  localparam logic [4:0] OP_XOR  = 5'b00101;
  localparam logic [4:0] OP_ADDS = 5'b00110;
  localparam logic [4:0] OP_SUBS = 5'b00111;
  localparam logic [4:0] OP_MUL  = 5'b01000;
  localparam logic [4:0] OP_MSW  = 5'b01001;
  localparam logic [4:0] OP_CMP  = 5'b01010;
  localparam logic [4:0] OP_NOP  = 5'b11111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/vector_fwd_mux.sv
// Operand select: takes the forwarded result when the source id
// matches the last retired destination (id 0 never forwards).
module vector_fwd_mux
  import vector_alu_pkg::*;
#(
  parameter int DATA_W = VA_DATA_W,
  parameter int ID_W   = VA_ID_W
) (
  input  logic              fwd_valid,
  input  logic [ID_W-1:0]   fwd_id,
  input  logic [DATA_W-1:0] fwd_y,
  input  logic [ID_W-1:0]   src_id,
  input  logic [DATA_W-1:0] src,
  output logic [DATA_W-1:0] sel
);

  logic hit;

  assign hit = fwd_valid && (src_id == fwd_id) && (src_id != '0);
  assign sel = hit ? fwd_y : src;

endmodule

// File: rtl/vector_alu_issue.sv
// Issue/execute control ahead of the combinational vector ALU:
// holds ALU inputs for the op latency and returns the result.
module vector_alu_issue
  import vector_alu_pkg::*;
#(
  parameter int DATA_W  = VA_DATA_W,
  parameter int OP_W    = 5,
  parameter int ID_W    = VA_ID_W,
  parameter int MUL_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [DATA_W-1:0] in_r,
  input  logic [DATA_W-1:0] in_s,
  input  logic [ID_W-1:0]   in_r_id,
  input  logic [ID_W-1:0]   in_s_id,
  input  logic [ID_W-1:0]   in_dst_id,
  output logic [DATA_W-1:0] alu_r,
  output logic [DATA_W-1:0] alu_s,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_y,
  output logic [ID_W-1:0]   out_dst_id,
  output logic              out_err,
  output logic              busy
);

  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [OP_W-1:0] NOP = OP_W'(OP_NOP);
  localparam logic [OP_W-1:0] MUL = OP_W'(OP_MUL);
  localparam logic [OP_W-1:0] MSW = OP_W'(OP_MSW);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [ID_W-1:0]   dst_q;
  logic [DATA_W-1:0] fwd_y;
  logic [ID_W-1:0]   fwd_id;
  logic              fwd_valid;
  logic              last_was_mul;
  logic [DATA_W-1:0] r_sel;
  logic [DATA_W-1:0] s_sel;

  vector_fwd_mux #(.DATA_W(DATA_W), .ID_W(ID_W)) u_fwd_r (
    .fwd_valid (fwd_valid),
    .fwd_id    (fwd_id),
    .fwd_y     (fwd_y),
    .src_id    (in_r_id),
    .src       (in_r),
    .sel       (r_sel)
  );

  vector_fwd_mux #(.DATA_W(DATA_W), .ID_W(ID_W)) u_fwd_s (
    .fwd_valid (fwd_valid),
    .fwd_id    (fwd_id),
    .fwd_y     (fwd_y),
    .src_id    (in_s_id),
    .src       (in_s),
    .sel       (s_sel)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == RESP);
  assign busy      = (state != IDLE);

  // alu_op doubles as the latched opcode: it is only non-NOP in BUSY
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      dst_q        <= '0;
      alu_r        <= '0;
      alu_s        <= '0;
      alu_op       <= NOP;
      out_y        <= '0;
      out_dst_id   <= '0;
      out_err      <= 1'b0;
      fwd_y        <= '0;
      fwd_id       <= '0;
      fwd_valid    <= 1'b0;
      last_was_mul <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && (in_op != NOP)) begin
            dst_q  <= in_dst_id;
            alu_op <= in_op;
            alu_r  <= r_sel;
            alu_s  <= s_sel;
            cnt    <= (in_op == MUL) ? CNT_W'(MUL_LAT - 1) : '0;
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            out_y        <= alu_y;
            out_dst_id   <= dst_q;
            out_err      <= (alu_op == MSW) && !last_was_mul;
            last_was_mul <= (alu_op == MUL);
            alu_op       <= NOP;
            state        <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (out_ready) begin
            fwd_y     <= out_y;
            fwd_id    <= out_dst_id;
            fwd_valid <= (out_dst_id != '0);
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/vector_alu_issue.md
Name: vector_alu_issue

Overview:
- Issue/execute-control stage directly upstream of the 64-bit vector ALU.
- Accepts one operation per valid/ready handshake, with single-entry result forwarding.
- Drives the combinational ALU's R/S/op inputs and holds them stable for the op's latency: multiply gets MUL_LAT cycles, everything else 1.
- Captures the ALU result and presents it downstream on a valid/ready interface. One op in flight at a time.

Parameters:
- DATA_W, 64, operand/result width
- OP_W, 5, ALU opcode width
- ID_W, 5, register-id width; id 0 is never forwarded
- MUL_LAT, 4, cycles ALU inputs are held for opcode MUL (must be ≥1)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream op valid
- in_ready  out  1  stage can accept
- in_op  in  OP_W  ALU opcode
- in_r, in_s  in  DATA_W  register-file operands
- in_r_id, in_s_id  in  ID_W  source register ids
- in_dst_id  in  ID_W  destination id
- alu_r, alu_s  out  DATA_W  to ALU R/S
- alu_op  out  OP_W  to ALU op
- alu_y  in  DATA_W  from ALU Y
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_y  out  DATA_W  captured result
- out_dst_id  out  ID_W  destination of result
- out_err  out  1  sequencing error flag for this result
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, any state): state=IDLE, in_ready=1, out_valid=0, out_y=0, out_dst_id=0, out_err=0, alu_r=alu_s=0, alu_op=NOP (5'b11111), fwd_valid=0, last_was_mul=0, counter=0.
- States:
  - IDLE: in_ready=1.
  - BUSY: counting.
  - RESP: out_valid=1.
- IDLE, in_valid=1, op != NOP:
  - Latch op and dst.
  - alu_r = fwd_y if (fwd_valid && in_r_id==fwd_id && in_r_id!=0), else in_r; same rule for alu_s.
  - Load counter = MUL_LAT-1 if op==MUL (5'b01000), else 0.
  - Go to BUSY.
- IDLE, in_valid=1, op == NOP:
  - Consumed in one cycle; no result, no forwarding update. Stay IDLE.
- BUSY:
  - alu_r/alu_s/alu_op held constant every cycle.
  - Counter decrements each cycle.
  - At the edge where counter==0: out_y<=alu_y, out_dst_id<=dst, out_err<=err. Go to RESP.
- Latency: out_valid rises L edges after the accept edge (L=MUL_LAT for MUL, 1 otherwise). Minimum 3-cycle issue interval.
- out_err:
  - 1 iff op==MSW (5'b01001) and the previously retired non-NOP op was not MUL. Result is still delivered.
  - last_was_mul updates at each retire.
- RESP:
  - out_y/out_dst_id/out_err held stable while out_ready=0; in_ready=0.
  - On out_ready=1: go to IDLE, and set fwd_y<=out_y, fwd_id<=out_dst_id.
  - fwd_valid<=1 only if out_dst_id!=0; otherwise fwd_valid<=0.
- Outside BUSY: alu_op=NOP; alu_r/alu_s keep their last values.
- All opcodes other than MUL and NOP take the 1-cycle path, including undefined ones.

Decomposition:
- Shared package vector_alu_pkg holds:
  - opcode constants: ADD 5'b00000, PASS 5'b00001, SUB 5'b00010, AND 5'b00011, OR 5'b00100, XOR 5'b00101, ADDS 5'b00110, SUBS 5'b00111, MUL 5'b01000, MSW 5'b01001, CMP 5'b01010, NOP 5'b11111
  - state enum {IDLE, BUSY, RESP}
  - DATA_W/ID_W defaults
- One sub-module: vector_fwd_mux (combinational operand select; instantiated twice for R and S).

Test Plan:
- ADD: in_r=5, in_s=7, dst=2, out_ready=1 → alu_op=00000 for exactly 1 cycle; out_y=12 with out_valid at the 1st edge after accept; out_err=0.
- MUL with MUL_LAT=4: R=3, S=0xFFFF_FFFF_FFFF_FFFE → alu_op=01000 stable for 4 cycles; out_y=0xFFFF_FFFF_FFFF_FFFA; out_valid at the 4th edge after accept.
- Forwarding:
  - ADD with dst=3 returns 12 and retires; next op has in_r_id=3, in_r=0 → alu_r=12.
  - Repeat with dst=0 → alu_r=0 (no forward).
- MSW sequencing: MSW after ADD → out_err=1; MSW after MUL → out_err=0.
- Backpressure: hold out_ready=0 for 5 cycles in RESP → out_valid=1, out_y unchanged, in_ready=0; release → in_ready=1 the next cycle.
- Reset mid-MUL: assert rst during the 2nd BUSY cycle → out_valid=0, alu_op=NOP immediately; after release in_ready=1; a subsequent op with a matching source id is not forwarded.
